// File: rtl/timer_pkg.sv
// Shared types and constants for the timer controller: FSM states, register
// addresses and CTRL/STATUS bit positions.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_PRESCALE = 3'd1;
   localparam logic [2:0] ADDR_MIN      = 3'd2;
   localparam logic [2:0] ADDR_MAX      = 3'd3;
   localparam logic [2:0] ADDR_INIT     = 3'd4;
   localparam logic [2:0] ADDR_STATUS   = 3'd5;
   localparam logic [2:0] ADDR_VALUE    = 3'd6;
   localparam logic [2:0] ADDR_RSVD     = 3'd7;

   localparam int CTRL_START   = 0;
   localparam int CTRL_MODE    = 1;
   localparam int CTRL_FREE    = 2;
   localparam int CTRL_ONESHOT = 3;
   localparam int CTRL_IRQ_EN  = 4;
   localparam int CTRL_W       = 5;

   localparam int STAT_OVF     = 0;
   localparam int STAT_RUNNING = 1;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: ticks once every PRESCALE+1 run cycles; a lowered PRESCALE fires
// as soon as the running count reaches or exceeds it.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             run,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] pre_cnt_r;

   assign tick = run & (pre_cnt_r >= prescale);

   // Run-cycle counter, restarted on LOAD and after every tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_r <= {PRE_W{1'b0}};
      end else if (clr || tick) begin
         pre_cnt_r <= {PRE_W{1'b0}};
      end else if (run) begin
         pre_cnt_r <= pre_cnt_r + PRE_W'(1'b1);
      end else begin
         pre_cnt_r <= pre_cnt_r;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Register-mapped controller for timer_counter: configuration registers,
// IDLE/LOAD/RUN sequencing, prescaled enable and sticky overflow interrupt.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter  int COUNTER_SIZE = 8,
   parameter  int PRE_W        = 8,
   localparam int DW           = max_w(COUNTER_SIZE, PRE_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic [2:0]              addr,
   input  logic [DW-1:0]           wdata,
   output logic [DW-1:0]           rdata,
   output logic                    rdata_vld,
   output logic                    cnt_en,
   output logic                    cnt_mode,
   output logic                    cnt_free,
   output logic                    init_cnt,
   output logic [COUNTER_SIZE-1:0] cnt_min,
   output logic [COUNTER_SIZE-1:0] cnt_max,
   output logic [COUNTER_SIZE-1:0] cnt_init,
   input  logic [COUNTER_SIZE-1:0] cnt_value,
   input  logic                    overflow_set,
   output logic                    irq
);

   state_e                  state_r;
   logic [CTRL_W-1:0]       ctrl_r;
   logic [CTRL_W-1:0]       ctrl_nxt_s;
   logic [PRE_W-1:0]        prescale_r;
   logic [COUNTER_SIZE-1:0] min_r;
   logic [COUNTER_SIZE-1:0] max_r;
   logic [COUNTER_SIZE-1:0] init_r;
   logic                    ovf_r;
   logic                    init_cnt_r;
   logic [DW-1:0]           rdata_r;
   logic                    rdata_vld_r;
   logic [DW-1:0]           rd_mux_s;

   logic wr_ctrl_s;
   logic wr_status_s;
   logic run_s;
   logic running_s;
   logic tick_s;
   logic evt_s;
   logic oneshot_stop_s;

   assign wr_ctrl_s      = wr_en & (addr == ADDR_CTRL);
   assign wr_status_s    = wr_en & (addr == ADDR_STATUS);
   assign run_s          = (state_r == RUN);
   assign running_s      = (state_r == LOAD) | (state_r == RUN);
   assign evt_s          = overflow_set & tick_s & run_s;
   assign oneshot_stop_s = evt_s & ctrl_r[CTRL_ONESHOT];

   timer_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (state_r == LOAD),
      .run      (run_s),
      .prescale (prescale_r),
      .tick     (tick_s)
   );

   // CTRL next value: a host write lands first, a oneshot stop then drops start
   always_comb begin
      if (wr_ctrl_s) begin
         ctrl_nxt_s = wdata[CTRL_W-1:0];
      end else begin
         ctrl_nxt_s = ctrl_r;
      end
      if (oneshot_stop_s) begin
         ctrl_nxt_s[CTRL_START] = 1'b0;
      end else begin
         ctrl_nxt_s[CTRL_START] = ctrl_nxt_s[CTRL_START];
      end
   end

   // Run/stop sequencing with a registered one-cycle load pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         init_cnt_r <= 1'b0;
      end else begin
         init_cnt_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (wr_ctrl_s && wdata[CTRL_START]) begin
                  state_r    <= LOAD;
                  init_cnt_r <= 1'b1;
               end
            end
            LOAD: state_r <= RUN;
            RUN: begin
               if (oneshot_stop_s || (wr_ctrl_s && !wdata[CTRL_START])) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Configuration registers and sticky overflow (a new event beats W1C)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_r     <= {CTRL_W{1'b0}};
         prescale_r <= {PRE_W{1'b0}};
         min_r      <= {COUNTER_SIZE{1'b0}};
         max_r      <= {COUNTER_SIZE{1'b0}};
         init_r     <= {COUNTER_SIZE{1'b0}};
         ovf_r      <= 1'b0;
      end else begin
         ctrl_r <= ctrl_nxt_s;
         if (wr_en && addr == ADDR_PRESCALE) prescale_r <= wdata[PRE_W-1:0];
         if (wr_en && addr == ADDR_MIN)      min_r      <= wdata[COUNTER_SIZE-1:0];
         if (wr_en && addr == ADDR_MAX)      max_r      <= wdata[COUNTER_SIZE-1:0];
         if (wr_en && addr == ADDR_INIT)     init_r     <= wdata[COUNTER_SIZE-1:0];
         if (evt_s) begin
            ovf_r <= 1'b1;
         end else if (wr_status_s && wdata[STAT_OVF]) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Read decode from current register state, so a colliding write reads old data
   always_comb begin
      rd_mux_s = {DW{1'b0}};
      case (addr)
         ADDR_CTRL:     rd_mux_s = DW'(ctrl_r);
         ADDR_PRESCALE: rd_mux_s = DW'(prescale_r);
         ADDR_MIN:      rd_mux_s = DW'(min_r);
         ADDR_MAX:      rd_mux_s = DW'(max_r);
         ADDR_INIT:     rd_mux_s = DW'(init_r);
         ADDR_STATUS:   rd_mux_s = DW'({running_s, ovf_r});
         ADDR_VALUE:    rd_mux_s = DW'(cnt_value);
         default:       rd_mux_s = {DW{1'b0}};
      endcase
   end

   // Registered read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r     <= {DW{1'b0}};
         rdata_vld_r <= 1'b0;
      end else begin
         rdata_vld_r <= rd_en;
         rdata_r     <= rd_en ? rd_mux_s : {DW{1'b0}};
      end
   end

   assign rdata     = rdata_r;
   assign rdata_vld = rdata_vld_r;
   assign cnt_en    = tick_s;
   assign init_cnt  = init_cnt_r;
   assign cnt_mode  = ctrl_r[CTRL_MODE];
   assign cnt_free  = ctrl_r[CTRL_FREE];
   assign cnt_min   = min_r;
   assign cnt_max   = max_r;
   assign cnt_init  = init_r;
   assign irq       = ctrl_r[CTRL_IRQ_EN] & ovf_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: register table, directed multi-cycle sequences with a
// small counter stand-in, and randomized traffic against a reference model.
module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en;
   logic [2:0] addr;
   logic [7:0] wdata, rdata;
   logic       rdata_vld, cnt_en, cnt_mode, cnt_free, init_cnt, irq;
   logic [7:0] cnt_min, cnt_max, cnt_init, cnt_value;
   logic       overflow_set;

   logic       use_stub = 1'b0;
   logic [7:0] tb_val = 8'h00;
   logic       tb_ovf = 1'b0;
   logic [7:0] stub_val;
   logic       stub_ovf;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   timer_ctrl #(.COUNTER_SIZE(8), .PRE_W(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rdata_vld(rdata_vld), .cnt_en(cnt_en),
      .cnt_mode(cnt_mode), .cnt_free(cnt_free), .init_cnt(init_cnt),
      .cnt_min(cnt_min), .cnt_max(cnt_max), .cnt_init(cnt_init),
      .cnt_value(cnt_value), .overflow_set(overflow_set), .irq(irq)
   );

   // Stand-in for timer_counter: load, step toward the limit, flag at the limit
   assign stub_ovf = cnt_mode ? (stub_val == cnt_max) : (stub_val == cnt_min);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stub_val <= 8'h00;
      else if (init_cnt) stub_val <= cnt_init;
      else if (cnt_en) begin
         if (stub_ovf) stub_val <= cnt_mode ? cnt_min : cnt_max;
         else stub_val <= cnt_mode ? stub_val + 8'd1 : stub_val - 8'd1;
      end
   end

   assign cnt_value    = use_stub ? stub_val : tb_val;
   assign overflow_set = use_stub ? stub_ovf : tb_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d);
      wr_en = w; rd_en = r; addr = a; wdata = d;
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      bus(1'b1, 1'b0, a, d);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
      bus(1'b0, 1'b1, a, 8'h00);
      check({name, "_vld"}, rdata_vld, 1);
      check(name, rdata, exp);
   endtask

   task automatic do_reset();
      wr_en = 1'b0; rd_en = 1'b0; addr = 3'd0; wdata = 8'h00; tb_ovf = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   typedef struct {
      logic       wr;
      logic       rd;
      logic [2:0] a;
      logic [7:0] d;
      logic [7:0] val;
      logic       exp_vld;
      logic [7:0] exp_rdata;
   } vec_t;
   vec_t vq[$];

   // Reference model state (phase: 0 idle, 1 load, 2 run)
   int         m_phase, m_since;
   logic [4:0] m_ctrl;
   logic [7:0] m_pre, m_min, m_max, m_init, m_rdata;
   logic       m_ovf, m_vld;

   function automatic logic [7:0] m_read(input logic [2:0] a, input logic [7:0] v);
      case (a)
         3'd0: return {3'b000, m_ctrl};
         3'd1: return m_pre;
         3'd2: return m_min;
         3'd3: return m_max;
         3'd4: return m_init;
         3'd5: return {6'b000000, (m_phase != 0), m_ovf};
         3'd6: return v;
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      do_reset();
      check("rst_cnt_en", cnt_en, 0);
      check("rst_init_cnt", init_cnt, 0);
      check("rst_irq", irq, 0);
      check("rst_rdata_vld", rdata_vld, 0);
      check("rst_rdata", rdata, 0);

      // Register table: {wr, rd, addr, wdata, cnt_value, exp_vld, exp_rdata}
      for (int i = 0; i < 8; i++) vq.push_back('{1'b0, 1'b1, 3'(i), 8'h00, 8'h00, 1'b1, 8'h00});
      vq.push_back('{1'b1, 1'b0, 3'd1, 8'h5A, 8'h00, 1'b0, 8'h00});
      vq.push_back('{1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 8'h5A});
      vq.push_back('{1'b1, 1'b0, 3'd0, 8'hFE, 8'h00, 1'b0, 8'h00});
      vq.push_back('{1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 8'h1E});
      vq.push_back('{1'b1, 1'b0, 3'd7, 8'hFF, 8'h00, 1'b0, 8'h00});
      vq.push_back('{1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 1'b1, 8'h00});
      vq.push_back('{1'b1, 1'b1, 3'd2, 8'h11, 8'h00, 1'b1, 8'h00});
      vq.push_back('{1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 1'b1, 8'h11});
      vq.push_back('{1'b0, 1'b1, 3'd6, 8'h00, 8'hA5, 1'b1, 8'hA5});
      vq.push_back('{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00});
      vq.push_back('{1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00});
      vq.push_back('{1'b0, 1'b1, 3'd5, 8'h00, 8'h00, 1'b1, 8'h00});
      foreach (vq[i]) begin
         tb_val = vq[i].val;
         bus(vq[i].wr, vq[i].rd, vq[i].a, vq[i].d);
         check($sformatf("tbl%0d_vld", i), rdata_vld, vq[i].exp_vld);
         if (vq[i].exp_vld) check($sformatf("tbl%0d_rdata", i), rdata, vq[i].exp_rdata);
         check($sformatf("tbl%0d_cnt_en", i), cnt_en, 0);
         check($sformatf("tbl%0d_irq", i), irq, 0);
      end

      // Start sequence: up count 250..255, overflow, irq, clear
      use_stub = 1'b1;
      do_reset();
      wr(3'd3, 8'hFF); wr(3'd4, 8'd250); wr(3'd1, 8'h00);
      wr(3'd0, 8'h13);
      check("start_init_cnt_t1", init_cnt, 1);
      check("start_cnt_en_t1", cnt_en, 0);
      cyc();
      check("start_init_cnt_t2", init_cnt, 0);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("start_val%0d", k), cnt_value, 250 + k);
         check($sformatf("start_en%0d", k), cnt_en, 1);
         check($sformatf("start_irq%0d", k), irq, 0);
         if (k < 5) cyc();
      end
      cyc();
      check("start_irq_set", irq, 1);
      wr(3'd5, 8'h01);
      check("start_irq_clr", irq, 0);
      rd_chk("start_status", 3'd5, 8'h02);

      // Prescaler: 1-in-4, then lower PRESCALE below the running count
      use_stub = 1'b0;
      do_reset();
      wr(3'd1, 8'd3);
      wr(3'd0, 8'h01);
      for (int k = 0; k < 8; k++) begin
         cyc();
         check($sformatf("pre3_en%0d", k), cnt_en, (k % 4) == 3);
      end
      wr(3'd1, 8'd7);
      check("pre7_en0", cnt_en, 0);
      cyc(); cyc();
      cyc();
      check("pre7_en3", cnt_en, 0);
      wr(3'd1, 8'd1);
      check("pre1_fire", cnt_en, 1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check($sformatf("pre1_en%0d", k), cnt_en, (k % 2) == 1);
      end

      // Oneshot down count
      use_stub = 1'b1;
      do_reset();
      wr(3'd3, 8'd10); wr(3'd4, 8'd2);
      wr(3'd0, 8'h09);
      check("os_init_cnt", init_cnt, 1);
      cyc(); cyc(); cyc();
      check("os_val0", cnt_value, 0);
      check("os_en_evt", cnt_en, 1);
      cyc();
      check("os_en_off", cnt_en, 0);
      rd_chk("os_status", 3'd5, 8'h01);
      rd_chk("os_ctrl", 3'd0, 8'h08);
      check("os_en_stay_off", cnt_en, 0);

      // Collisions: W1C vs event, stop mid-run
      use_stub = 1'b0;
      do_reset();
      wr(3'd0, 8'h11);
      cyc();
      check("col_en", cnt_en, 1);
      tb_ovf = 1'b1;
      wr(3'd5, 8'h01);
      tb_ovf = 1'b0;
      check("col_w1c_irq", irq, 1);
      rd_chk("col_status", 3'd5, 8'h03);
      wr(3'd5, 8'h01);
      check("col_irq_clr", irq, 0);
      wr(3'd0, 8'h10);
      check("col_stop_en", cnt_en, 0);
      rd_chk("col_stop_status", 3'd5, 8'h00);

      // Asynchronous reset mid-run
      wr(3'd3, 8'h77);
      wr(3'd0, 8'h13);
      cyc();
      tb_ovf = 1'b1;
      cyc();
      tb_ovf = 1'b0;
      check("arst_pre_irq", irq, 1);
      rd_chk("arst_pre_ctrl", 3'd0, 8'h13);
      rst = 1'b1;
      #1;
      check("arst_cnt_en", cnt_en, 0);
      check("arst_irq", irq, 0);
      check("arst_vld", rdata_vld, 0);
      check("arst_rdata", rdata, 0);
      check("arst_mode", cnt_mode, 0);
      check("arst_max", cnt_max, 0);
      check("arst_init_cnt", init_cnt, 0);
      cyc();
      rst = 1'b0;

      // Randomized traffic against the reference model
      do_reset();
      m_phase = 0; m_since = 0; m_ctrl = 5'h00; m_pre = 8'h00; m_min = 8'h00;
      m_max = 8'h00; m_init = 8'h00; m_ovf = 1'b0; m_vld = 1'b0; m_rdata = 8'h00;
      for (int n = 0; n < 1500; n++) begin
         logic       w, r, o, tick, ev, stop1;
         logic [2:0] a;
         logic [7:0] d, v;
         w = ($urandom_range(0, 9) < 3);
         r = ($urandom_range(0, 9) < 4);
         a = 3'($urandom_range(0, 7));
         d = 8'($urandom);
         if (a == 3'd1) d = 8'($urandom_range(0, 5));
         v = 8'($urandom);
         o = ($urandom_range(0, 3) == 0);
         wr_en = w; rd_en = r; addr = a; wdata = d; tb_val = v; tb_ovf = o;
         #1;
         tick = (m_phase == 2) && (m_since >= int'(m_pre));
         check("rnd_cnt_en", cnt_en, tick);
         check("rnd_init_cnt", init_cnt, m_phase == 1);
         check("rnd_irq", irq, m_ctrl[4] & m_ovf);
         check("rnd_vld", rdata_vld, m_vld);
         if (m_vld) check("rnd_rdata", rdata, m_rdata);
         check("rnd_cfg", {cnt_mode, cnt_free, cnt_min, cnt_max, cnt_init},
               {m_ctrl[1], m_ctrl[2], m_min, m_max, m_init});
         @(posedge clk);
         ev    = tick && o;
         stop1 = ev && m_ctrl[3];
         m_vld = r;
         m_rdata = r ? m_read(a, v) : 8'h00;
         if (m_phase == 1) m_since = 0;
         else if (m_phase == 2) m_since = tick ? 0 : m_since + 1;
         if (w) begin
            case (a)
               3'd0: m_ctrl = d[4:0];
               3'd1: m_pre  = d;
               3'd2: m_min  = d;
               3'd3: m_max  = d;
               3'd4: m_init = d;
               default: ;
            endcase
         end
         if (stop1) m_ctrl[0] = 1'b0;
         if (ev) m_ovf = 1'b1;
         else if (w && a == 3'd5 && d[0]) m_ovf = 1'b0;
         if (m_phase == 0) m_phase = (w && a == 3'd0 && d[0]) ? 1 : 0;
         else if (m_phase == 1) m_phase = 2;
         else if (stop1 || (w && a == 3'd0 && !d[0])) m_phase = 0;
         #1;
      end
      wr_en = 1'b0; rd_en = 1'b0; tb_ovf = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
